instr_fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the RISC datapath/control pair. It owns the fetch PC and issues in-order requests to instruction memory, with up to FIFO_DEPTH requests in flight. Returned words go into a small prefetch FIFO, which is handed to decode over a valid/ready handshake. Taken branches and jumps from downstream redirect the PC, flush the FIFO and discard stale responses still in flight.

---
 rtl/instr_fetch_unit.sv | 127 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, keeps up to FIFO_DEPTH memory requests
// in flight, buffers returned words in a prefetch FIFO, and flushes on redirect.
module instr_fetch_unit #(
    parameter int                ADDR_W     = 16,
    parameter int                INSTR_W    = 16,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

    typedef enum logic {S_BOOT, S_FETCH} state_t;

    state_t state_q, state_n;

    logic [ADDR_W-1:0]  fetch_pc;
    logic [INSTR_W-1:0] fifo_instr [FIFO_DEPTH];
    logic [ADDR_W-1:0]  fifo_pc    [FIFO_DEPTH];
    logic [ADDR_W-1:0]  aq         [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr, rd_ptr_n, aq_wr, aq_rd;
    logic [CNT_W-1:0]   fifo_count, count_n, outstanding, outstanding_n, drop_cnt;
    logic [CNT_W:0]     credit_used;
    logic               grant, rsp, push, pop;
    logic [INSTR_W-1:0] head_instr;
    logic [ADDR_W-1:0]  head_pc;

    // Every in-flight request holds a FIFO slot, so credit covers both.
    assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};

    always_comb begin
        state_n  = state_q;
        imem_req = 1'b0;
        case (state_q)
            S_BOOT:  state_n = S_FETCH;
            S_FETCH: imem_req = !redirect && (credit_used < DEPTH_C);
            default: state_n = S_BOOT;
        endcase
    end

    assign imem_addr = {fetch_pc[ADDR_W-1:1], 1'b0};

    assign grant         = imem_req && imem_gnt;
    assign rsp           = imem_rvalid && (outstanding != '0);
    assign push          = rsp && (drop_cnt == '0) && !redirect;
    assign pop           = instr_valid && instr_ready;
    assign outstanding_n = outstanding + CNT_W'(grant) - CNT_W'(rsp);
    assign count_n       = fifo_count + CNT_W'(push) - CNT_W'(pop);
    assign rd_ptr_n      = rd_ptr + PTR_W'(pop);

    // Next head: the word being written lands on the head only when the FIFO drains to empty.
    always_comb begin
        head_instr = fifo_instr[rd_ptr_n];
        head_pc    = fifo_pc[rd_ptr_n];
        if (push && (wr_ptr == rd_ptr_n)) begin
            head_instr = imem_rdata;
            head_pc    = aq[aq_rd];
        end
    end

    always_ff @(posedge clk) begin
        if (grant) aq[aq_wr] <= fetch_pc;
        if (push) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= aq[aq_rd];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_BOOT;
            fetch_pc    <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            aq_wr       <= '0;
            aq_rd       <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            state_q     <= state_n;
            outstanding <= outstanding_n;
            if (grant) aq_wr <= aq_wr + PTR_W'(1);
            if (rsp)   aq_rd <= aq_rd + PTR_W'(1);

            if (redirect)   fetch_pc <= redirect_pc & ~ADDR_W'(1);
            else if (grant) fetch_pc <= fetch_pc + ADDR_W'(2);

            // Everything still in flight at a redirect belongs to the old path.
            if (redirect)                   drop_cnt <= outstanding_n;
            else if (rsp && drop_cnt != '0) drop_cnt <= drop_cnt - CNT_W'(1);

            if (redirect) begin
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                fifo_count  <= '0;
                instr_valid <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                rd_ptr      <= rd_ptr_n;
                fifo_count  <= count_n;
                instr_valid <= (count_n != '0);
                if (count_n != '0) begin
                    instr    <= head_instr;
                    instr_pc <= head_pc;
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized traffic, checked each
// cycle against a queue-based model of in-flight requests and the prefetch buffer.
module tb_instr_fetch_unit;
    localparam int D = 2;

    logic        clk = 1'b0;
    logic        reset, imem_req, imem_gnt, imem_rvalid, redirect, instr_valid, instr_ready;
    logic [15:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;

    instr_fetch_unit #(.ADDR_W(16), .INSTR_W(16), .FIFO_DEPTH(D), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] a; bit stale; } inflight_t;
    typedef struct { logic [15:0] i; logic [15:0] pc; } entry_t;
    typedef struct { int due; logic [15:0] a; } memrsp_t;

    inflight_t iq[$];
    entry_t    fq[$];
    memrsp_t   mq[$];

    logic [15:0] m_pc = 16'h0, v_instr = 16'h0, v_pc = 16'h0, redir_target = 16'h0;
    bit          v_valid = 0, m_fetch = 0, e_req = 0, redir_on_rv = 0, spur = 0;
    int          errors = 0, checks = 0, cyc = 0;
    int          lat = 1, gnt_pct = 100, rdy_pct = 100, rv_pct = 100;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input bit rst, input bit redir, input bit ck);
        inflight_t e;
        @(negedge clk);
        reset       = rst;
        redirect    = redir;
        redirect_pc = redir_target;
        instr_ready = ($urandom_range(99) < rdy_pct);
        imem_gnt    = rst ? 1'b0 : ($urandom_range(99) < gnt_pct);
        imem_rvalid = 1'b0;
        imem_rdata  = 16'($urandom);
        if (mq.size() > 0 && mq[0].due <= cyc && $urandom_range(99) < rv_pct) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mq[0].a ^ 16'hA5A5;
            void'(mq.pop_front());
        end else if (spur) begin
            imem_rvalid = 1'b1;
            spur = 0;
        end
        if (redir_on_rv && imem_rvalid) begin
            redirect    = 1'b1;
            redir_on_rv = 0;
        end
        #1;
        e_req = m_fetch && !redirect && (fq.size() + iq.size() < D);
        if (ck) begin
            chk("imem_req", 32'(imem_req), 32'(e_req));
            if (e_req) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
            chk("instr_valid", 32'(instr_valid), 32'(v_valid));
            chk("instr", 32'(instr), 32'(v_instr));
            chk("instr_pc", 32'(instr_pc), 32'(v_pc));
        end
        if (imem_req && imem_gnt) mq.push_back('{cyc + lat, imem_addr});
        @(posedge clk);
        if (reset) begin
            m_pc = 16'h0000; iq.delete(); fq.delete();
            v_valid = 0; v_instr = 16'h0; v_pc = 16'h0; m_fetch = 0;
        end else begin
            if (v_valid && instr_ready && fq.size() > 0) void'(fq.pop_front());
            if (imem_rvalid && iq.size() > 0) begin
                e = iq.pop_front();
                if (!e.stale && !redirect) fq.push_back('{imem_rdata, e.a});
            end
            if (e_req && imem_gnt) begin
                iq.push_back('{m_pc, 1'b0});
                m_pc = m_pc + 16'd2;
            end
            if (redirect) begin
                foreach (iq[k]) iq[k].stale = 1;
                fq.delete();
                m_pc = redirect_pc & 16'hFFFE;
            end
            m_fetch = 1;
            v_valid = !redirect && fq.size() > 0;
            if (v_valid) begin
                v_instr = fq[0].i;
                v_pc    = fq[0].pc;
            end
        end
        cyc++;
    endtask

    initial begin
        reset = 1; redirect = 0; redirect_pc = 0; imem_gnt = 0;
        imem_rvalid = 0; imem_rdata = 0; instr_ready = 0;

        // Reset, then zero-wait memory with decode always ready
        step(1, 0, 0);
        step(1, 0, 1);
        repeat (12) step(0, 0, 1);

        // Back-pressure: decode stalls, then drains
        rdy_pct = 0;
        repeat (8) step(0, 0, 1);
        rdy_pct = 100;
        repeat (6) step(0, 0, 1);

        // 3-cycle memory, redirect with two responses outstanding
        lat = 3;
        for (int i = 0; i < 20 && iq.size() != 2; i++) step(0, 0, 1);
        chk("two_outstanding", 32'(iq.size()), 32'd2);
        redir_target = 16'h0040;
        step(0, 1, 1);
        repeat (14) step(0, 0, 1);

        // Redirect to an odd target coincident with a returning word
        lat = 1;
        redir_target = 16'h0013;
        redir_on_rv = 1;
        for (int i = 0; i < 20 && redir_on_rv; i++) step(0, 0, 1);
        chk("redirect_with_rvalid", 32'(redir_on_rv), 32'd0);
        repeat (8) step(0, 0, 1);

        // Wrap of the fetch PC at the top of the address space
        redir_target = 16'hFFFC;
        step(0, 1, 1);
        repeat (10) step(0, 0, 1);

        // Randomized traffic
        gnt_pct = 70; rdy_pct = 60; rv_pct = 70;
        for (int i = 0; i < 300; i++) begin
            if (i % 50 == 0) lat = $urandom_range(1, 3);
            redir_target = 16'($urandom);
            step(0, ($urandom_range(99) < 5), 1);
        end

        // Reset mid-stream with responses still in flight; late and spurious rvalids ignored
        gnt_pct = 100; rdy_pct = 100; rv_pct = 100; lat = 3;
        for (int i = 0; i < 30 && iq.size() != 2; i++) step(0, 0, 1);
        chk("two_outstanding_pre_reset", 32'(iq.size()), 32'd2);
        repeat (3) step(1, 0, 1);
        spur = 1;
        step(0, 0, 1);
        repeat (12) step(0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
